lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
Panel-side receiver for the HD44780-style character LCD bus driven by the LCD write path (LCD_DATA, LCD_RW, LCD_EN, LCD_RS).
- Captures each bus write on the EN falling edge and decodes instruction versus character data.
- Keeps a 2x16 mirror of DDRAM, the address counter, a busy timer and a write-while-busy error flag.
- Serves as an on-chip display mirror (7-seg/debug readback) and as a self-checking endpoint for the LCD message sequencer.

Parameters:
EXEC_CYC, 2000, busy cycles after an ordinary instruction or data write (40 us at 50 MHz)
CLEAR_CYC, 82000, busy cycles after clear display / return home (1.64 ms at 50 MHz)
CNT_W, 17, busy counter width; must hold CLEAR_CYC

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
LCD_DATA  in  8  LCD data bus
LCD_RW  in  1  1=read, 0=write
LCD_EN  in  1  enable strobe; data is latched on its falling edge
LCD_RS  in  1  0=instruction, 1=character data
iRD_ADDR  in  5  mirror read index: 0-15 is line 1, 16-31 is line 2
oRD_CHAR  out  8  buffer[iRD_ADDR], combinational read
oCMD_VALID  out  1  one-cycle pulse when an instruction is committed
oCHAR_VALID  out  1  one-cycle pulse when a data write is committed
oCAPT  out  8  byte committed with the current pulse
oCUR_ADDR  out  7  DDRAM address counter
oBUSY  out  1  busy timer is nonzero
oDISP_ON  out  1  display-control D bit
oTWO_LINE  out  1  function-set N bit
oERR  out  1  sticky flag: a write arrived while busy

Behaviour:
- Reset (async, iRST_N=0) sets:
  - all 32 buffer entries to 0x20;
  - oCUR_ADDR=0x00 and internal ID=1 (increment);
  - oDISP_ON=0, oTWO_LINE=0, oERR=0;
  - busy counter=0, so oBUSY=0;
  - all pulses and oCAPT to 0.
  Reset mid-busy clears the counter immediately.
- Input capture:
  - LCD_EN, LCD_RS, LCD_RW and LCD_DATA pass through 2-FF synchronisers.
  - While synced EN=1, a shadow register samples RS/RW/DATA every cycle.
  - A falling edge of synced EN commits the shadow contents.
  - Commit occurs 3 iCLK after raw EN falls. Pulses and oCAPT assert in that cycle; state updates are visible on the following cycle.
- RW=1 commits are ignored: no state change, no pulse, no error.
- Busy rule:
  - A write while oBUSY=1 is dropped: no state change, no pulse, oERR<=1.
  - Otherwise, after executing, the counter loads EXEC_CYC, or CLEAR_CYC for clear/home.
  - The counter decrements by 1 per cycle down to 0.
- Instruction decode (RS=0) uses the highest set bit of DATA:
  - 0x01 clear: all buffer entries to 0x20, addr=0x00, ID=1.
  - 0x02-0x03 return home: addr=0x00; buffer unchanged.
  - 0x04-0x07 entry mode: ID=DATA[1]; S bit ignored.
  - 0x08-0x0F display control: oDISP_ON=DATA[2].
  - 0x10-0x1F shift: if DATA[3]=0, addr steps +1 when DATA[2]=1, else -1, using the wrap rule below. Display shift is ignored.
  - 0x20-0x3F function set: oTWO_LINE=DATA[3].
  - 0x40-0x7F set CGRAM address: accepted, no effect.
  - 0x80-0xFF set DDRAM address: addr=DATA[6:0].
  - 0x00: no effect, but busy still loads EXEC_CYC.
- Data write (RS=1):
  - addr 0x00-0x0F stores to buffer[addr]; addr 0x40-0x4F stores to buffer[16+addr-0x40]; any other address is not stored.
  - addr then steps by ID (+1 or -1).
- Address wrap for steps:
  - 0x27 +1 goes to 0x40; 0x67 +1 goes to 0x00.
  - 0x00 -1 goes to 0x67; 0x40 -1 goes to 0x27.
  - An illegal address loaded by set-DDRAM steps linearly modulo 128.
- The read port is combinational. A read of the entry being written in the same cycle returns the old value.

Test Plan:
- Bench overrides: EXEC_CYC=4, CLEAR_CYC=16. EN high 3 cycles per write; waits until oBUSY=0 unless a scenario says otherwise.
- Reset, then read all 32 indices -> every oRD_CHAR=0x20, oCUR_ADDR=0x00, oBUSY=0, oERR=0.
- Writes 0x038, 0x00C, 0x001, 0x006, 0x080 -> oTWO_LINE=1, oDISP_ON=1, oBUSY high exactly 16 cycles after 0x001, five oCMD_VALID pulses, oCUR_ADDR=0x00.
- Data 0x150 then 0x161 -> buffer[0]=0x50, buffer[1]=0x61, oCUR_ADDR=0x02, two oCHAR_VALID pulses with oCAPT=0x50 then 0x61.
- Instruction 0x0A7, data 0x141, data 0x142 -> 0x41 not stored, addr 0x27 wraps to 0x40, buffer[16]=0x42, oCUR_ADDR=0x41.
- Data 0x158 issued one cycle after the previous commit -> dropped, oERR=1 and stays 1, buffer unchanged, no oCHAR_VALID.
- Instruction 0x004, DDRAM 0x080, data 0x15A -> buffer[0]=0x5A, oCUR_ADDR=0x67. Then clear 0x001 with reset asserted mid-busy -> oBUSY=0 at once, all outputs at reset values.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// Panel-side HD44780 bus receiver. It captures bus writes on the falling edge of EN
// and mirrors DDRAM (2x16), the address counter, the busy timer and the display flags.
module lcd_bus_receiver #(
    parameter int EXEC_CYC  = 2000,
    parameter int CLEAR_CYC = 82000,
    parameter int CNT_W     = 17
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_CHAR,
    output logic       oCMD_VALID,
    output logic       oCHAR_VALID,
    output logic [7:0] oCAPT,
    output logic [6:0] oCUR_ADDR,
    output logic       oBUSY,
    output logic       oDISP_ON,
    output logic       oTWO_LINE,
    output logic       oERR
);

    logic [1:0]       enSync, rsSync, rwSync;
    logic [7:0]       dataSync1, dataSync2;
    logic             enPrev;
    logic             shadowRs, shadowRw;
    logic [7:0]       shadowData;
    logic             commitDet;
    logic             incDir;
    logic [CNT_W-1:0] busyCnt;
    logic [7:0]       charBuf [32];

    logic [6:0]       addrNext;
    logic             idNext, dispNext, twoNext, clearAll, wrEn;
    logic [4:0]       wrIdx;
    logic [CNT_W-1:0] loadVal;

    function automatic logic [6:0] stepAddr(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign commitDet = enPrev & ~enSync[1];
    assign oBUSY     = (busyCnt != '0);
    assign oRD_CHAR  = charBuf[iRD_ADDR];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            enSync     <= '0;
            rsSync     <= '0;
            rwSync     <= '0;
            dataSync1  <= '0;
            dataSync2  <= '0;
            enPrev     <= 1'b0;
            shadowRs   <= 1'b0;
            shadowRw   <= 1'b0;
            shadowData <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
            enSync    <= {enSync[0], LCD_EN};
            rsSync    <= {rsSync[0], LCD_RS};
            rwSync    <= {rwSync[0], LCD_RW};
            dataSync1 <= LCD_DATA;
            dataSync2 <= dataSync1;
            enPrev    <= enSync[1];
            if (enSync[1]) begin
                shadowRs   <= rsSync[1];
                shadowRw   <= rwSync[1];
                shadowData <= dataSync2;
            end
        end
    end

    // The pulse registers double as the execute strobe for the next cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCMD_VALID  <= 1'b0;
            oCHAR_VALID <= 1'b0;
            oCAPT       <= '0;
            oERR        <= 1'b0;
        end else begin
            oCMD_VALID  <= 1'b0;
            oCHAR_VALID <= 1'b0;
            if (commitDet && !shadowRw) begin
                if (oBUSY) begin
                    oERR <= 1'b1;
                end else begin
                    oCMD_VALID  <= ~shadowRs;
                    oCHAR_VALID <= shadowRs;
                    oCAPT       <= shadowData;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        addrNext = oCUR_ADDR;
        idNext   = incDir;
        dispNext = oDISP_ON;
        twoNext  = oTWO_LINE;
        clearAll = 1'b0;
        wrEn     = 1'b0;
        wrIdx    = {oCUR_ADDR[6], oCUR_ADDR[3:0]};
        loadVal  = CNT_W'(EXEC_CYC);
        if (oCHAR_VALID) begin
            wrEn     = (oCUR_ADDR[6:4] == 3'b000) || (oCUR_ADDR[6:4] == 3'b100);
            addrNext = stepAddr(oCUR_ADDR, incDir);
        end else if (oCMD_VALID) begin
            casez (oCAPT)
                8'b1???????: addrNext = oCAPT[6:0];
                8'b01??????: ;
                8'b001?????: twoNext = oCAPT[3];
                8'b0001????: if (!oCAPT[3]) addrNext = stepAddr(oCUR_ADDR, oCAPT[2]);
                8'b00001???: dispNext = oCAPT[2];
                8'b000001??: idNext = oCAPT[1];
                8'b0000001?: begin
                    addrNext = 7'h00;
                    loadVal  = CNT_W'(CLEAR_CYC);
                end
                8'b00000001: begin
                    clearAll = 1'b1;
                    addrNext = 7'h00;
                    idNext   = 1'b1;
                    loadVal  = CNT_W'(CLEAR_CYC);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCUR_ADDR <= '0;
            incDir    <= 1'b1;
            oDISP_ON  <= 1'b0;
            oTWO_LINE <= 1'b0;
            busyCnt   <= '0;
        end else begin
            oCUR_ADDR <= addrNext;
            incDir    <= idNext;
            oDISP_ON  <= dispNext;
            oTWO_LINE <= twoNext;
            if (oCMD_VALID || oCHAR_VALID) busyCnt <= loadVal;
            else if (oBUSY)                busyCnt <= busyCnt - 1'b1;
        end
    end

    // NOTE: the mirror must show blanks straight out of reset, so it is a reset register file rather than a RAM.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) charBuf[i] <= 8'h20;
        end else if (clearAll) begin
            for (int i = 0; i < 32; i++) charBuf[i] <= 8'h20;
        end else if (wrEn) begin
            charBuf[wrIdx] <= oCAPT;
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with short busy times so whole command sequences run quickly.
module tb_lcd_bus_receiver;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [7:0] LCD_DATA = '0;
    logic       LCD_RW = 1'b0;
    logic       LCD_EN = 1'b0;
    logic       LCD_RS = 1'b0;
    logic [4:0] iRD_ADDR = '0;
    logic [7:0] oRD_CHAR, oCAPT;
    logic       oCMD_VALID, oCHAR_VALID, oBUSY, oDISP_ON, oTWO_LINE, oERR;
    logic [6:0] oCUR_ADDR;

    int testCount = 0;
    int failCount = 0;
    int cmdPulses = 0;
    int charPulses = 0;
    logic [7:0] captQ[$];
    int busyCyc;
    int waitCyc;

    lcd_bus_receiver #(.EXEC_CYC(4), .CLEAR_CYC(16), .CNT_W(17)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .iRD_ADDR(iRD_ADDR), .oRD_CHAR(oRD_CHAR),
        .oCMD_VALID(oCMD_VALID), .oCHAR_VALID(oCHAR_VALID), .oCAPT(oCAPT),
        .oCUR_ADDR(oCUR_ADDR), .oBUSY(oBUSY), .oDISP_ON(oDISP_ON),
        .oTWO_LINE(oTWO_LINE), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (iRST_N && oCMD_VALID) cmdPulses++;
        if (iRST_N && oCHAR_VALID) begin
            charPulses++;
            captQ.push_back(oCAPT);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic readChar(input int idx, input logic [7:0] expected, input string tag);
        iRD_ADDR = 5'(idx);
        #1;
        check(tag, 32'(oRD_CHAR), 32'(expected));
    endtask

    // One bus write with EN high for enCyc cycles; returns how many cycles oBUSY stayed high.
    task automatic lcdWrite(input logic rs, input logic [7:0] d, output int busyOut);
        @(negedge iCLK);
        LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (3) @(negedge iCLK);
        LCD_EN = 1'b0;
        busyOut = 0;
        for (int i = 0; i < 8 && !oBUSY; i++) @(negedge iCLK);
        while (oBUSY && busyOut < 1000) begin
            busyOut++;
            @(negedge iCLK);
        end
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        check("rst_addr_in_reset", 32'(oCUR_ADDR), 32'h00);
        check("rst_busy_in_reset", 32'(oBUSY), 32'h0);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        for (int i = 0; i < 32; i++) readChar(i, 8'h20, "rst_buf");
        check("rst_addr", 32'(oCUR_ADDR), 32'h00);
        check("rst_busy", 32'(oBUSY), 32'h0);
        check("rst_err", 32'(oERR), 32'h0);
        check("rst_disp", 32'(oDISP_ON), 32'h0);
        check("rst_two", 32'(oTWO_LINE), 32'h0);

        lcdWrite(1'b0, 8'h38, busyCyc);
        check("busy_exec_len", 32'(busyCyc), 32'd4);
        lcdWrite(1'b0, 8'h0C, busyCyc);
        lcdWrite(1'b0, 8'h01, busyCyc);
        check("busy_clear_len", 32'(busyCyc), 32'd16);
        lcdWrite(1'b0, 8'h06, busyCyc);
        lcdWrite(1'b0, 8'h80, busyCyc);
        check("init_two_line", 32'(oTWO_LINE), 32'h1);
        check("init_disp_on", 32'(oDISP_ON), 32'h1);
        check("init_cmd_pulses", 32'(cmdPulses), 32'd5);
        check("init_addr", 32'(oCUR_ADDR), 32'h00);

        lcdWrite(1'b1, 8'h50, busyCyc);
        lcdWrite(1'b1, 8'h61, busyCyc);
        readChar(0, 8'h50, "data_buf0");
        readChar(1, 8'h61, "data_buf1");
        check("data_addr", 32'(oCUR_ADDR), 32'h02);
        check("data_pulses", 32'(charPulses), 32'd2);
        check("data_capt0", 32'(captQ[0]), 32'h50);
        check("data_capt1", 32'(captQ[1]), 32'h61);
        check("data_err", 32'(oERR), 32'h0);

        lcdWrite(1'b0, 8'hA7, busyCyc);
        check("setddram_addr", 32'(oCUR_ADDR), 32'h27);
        lcdWrite(1'b1, 8'h41, busyCyc);
        check("wrap_addr", 32'(oCUR_ADDR), 32'h40);
        readChar(15, 8'h20, "offscreen_buf15");
        readChar(16, 8'h20, "offscreen_buf16");

        // 0x142 then 0x158 started one cycle after the 0x142 commit pulse
        @(negedge iCLK);
        LCD_RS = 1'b1; LCD_DATA = 8'h42; LCD_EN = 1'b1;
        repeat (3) @(negedge iCLK);
        LCD_EN = 1'b0;
        waitCyc = 0;
        while (!oCHAR_VALID && waitCyc < 10) begin
            @(negedge iCLK);
            waitCyc++;
        end
        check("commit_0x42_seen", 32'(oCHAR_VALID), 32'h1);
        LCD_DATA = 8'h58; LCD_EN = 1'b1;
        @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (30) @(negedge iCLK);
        readChar(16, 8'h42, "line2_buf16");
        readChar(17, 8'h20, "drop_buf17");
        check("drop_addr", 32'(oCUR_ADDR), 32'h41);
        check("drop_err", 32'(oERR), 32'h1);
        check("drop_char_pulses", 32'(charPulses), 32'd4);
        check("drop_capt_last", 32'(captQ[3]), 32'h42);

        lcdWrite(1'b0, 8'h04, busyCyc);
        lcdWrite(1'b0, 8'h80, busyCyc);
        lcdWrite(1'b1, 8'h5A, busyCyc);
        readChar(0, 8'h5A, "dec_buf0");
        check("dec_wrap_addr", 32'(oCUR_ADDR), 32'h67);
        check("err_sticky", 32'(oERR), 32'h1);

        @(negedge iCLK);
        LCD_RS = 1'b0; LCD_DATA = 8'h01; LCD_EN = 1'b1;
        repeat (3) @(negedge iCLK);
        LCD_EN = 1'b0;
        waitCyc = 0;
        while (!oBUSY && waitCyc < 10) begin
            @(negedge iCLK);
            waitCyc++;
        end
        check("clear_busy_seen", 32'(oBUSY), 32'h1);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("midrst_busy", 32'(oBUSY), 32'h0);
        check("midrst_addr", 32'(oCUR_ADDR), 32'h00);
        check("midrst_err", 32'(oERR), 32'h0);
        check("midrst_disp", 32'(oDISP_ON), 32'h0);
        check("midrst_two", 32'(oTWO_LINE), 32'h0);
        check("midrst_capt", 32'(oCAPT), 32'h00);
        check("midrst_cmd", 32'(oCMD_VALID), 32'h0);
        readChar(16, 8'h20, "midrst_buf16");
        readChar(0, 8'h20, "midrst_buf0");
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        check("postrst_busy", 32'(oBUSY), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
